// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose
//   Shares one single-port, byte-addressed, big-endian data memory between
//   two masters: m0 (CPU load/store stage) and m1 (DMA/debug loader).
//   It picks a winner, drives the memory strobes for exactly one cycle,
//   returns read data and pulses a one-cycle ack to the winner.
//
// Configuration
//   ALIGN_CHECK_EN (macro) : when defined, a granted request whose address is
//                            not word aligned or lies above MEM_SIZE-4 does
//                            not reach memory and is acked with err=1. When
//                            undefined, m0_err/m1_err are tied to 0 and every
//                            request is forwarded to memory.
//   MEM_SIZE               : data memory size in bytes (range check bound).
//   ROUND_ROBIN            : 1 = alternate on a tie, 0 = m0 always wins a tie.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   mX_req/we/addr/wdata    master X request (held until mX_ack)
//   mX_rdata                master X read data, held between reads
//   mX_ack, mX_err          master X one-cycle completion / error pulses
//   mem_write, mem_read     memory strobes, high for the single ACCESS cycle
//   mem_address             latched request address
//   mem_write_data          latched request write data
//   mem_read_data           data returned by memory
//   busy                    1 while a transaction is in flight
//   grant_id                master owning the current/last transaction
//   dbg_state               FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Handshake
//   A master raises req with we/addr/wdata valid and holds them until it sees
//   ack. The fields are latched at grant, so they may change after grant
//   without effect. ack (and err) is high for exactly one cycle; rdata is
//   valid while ack is high and holds until the next read by that master.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int MEM_SIZE    = 1024,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        busy,
    output logic        grant_id,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic        cur_we;
    logic        cur_bad;

    logic        winner;
    logic        any_req;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_bad;

    assign dbg_state = state;

    // Winner selection for the IDLE cycle. On a tie the round-robin build
    // favours whoever did not win last; reset leaves last_grant=1 so m0 takes
    // the first tie.
    always_comb begin
        any_req = m0_req | m1_req;
        winner  = 1'b0;
        if (m0_req && m1_req) begin
            winner = ROUND_ROBIN ? ~last_grant : 1'b0;
        end else if (m1_req) begin
            winner = 1'b1;
        end
        sel_we    = winner ? m1_we    : m0_we;
        sel_addr  = winner ? m1_addr  : m0_addr;
        sel_wdata = winner ? m1_wdata : m0_wdata;
`ifdef ALIGN_CHECK_EN
        sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr > 32'(MEM_SIZE - 4));
`else
        sel_bad = 1'b0;
`endif
    end

`ifndef ALIGN_CHECK_EN
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            cur_we         <= 1'b0;
            cur_bad        <= 1'b0;
            grant_id       <= 1'b0;
            busy           <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= 32'd0;
            mem_write_data <= 32'd0;
            m0_rdata       <= 32'd0;
            m1_rdata       <= 32'd0;
            m0_ack         <= 1'b0;
            m1_ack         <= 1'b0;
`ifdef ALIGN_CHECK_EN
            m0_err         <= 1'b0;
            m1_err         <= 1'b0;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
`ifdef ALIGN_CHECK_EN
            m0_err <= 1'b0;
            m1_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id       <= winner;
                        cur_we         <= sel_we;
                        cur_bad        <= sel_bad;
                        mem_address    <= sel_addr;
                        mem_write_data <= sel_wdata;
                        // Strobes are registered here so they are high for
                        // exactly the ACCESS cycle; a bad request never
                        // touches memory.
                        mem_write      <= sel_we & ~sel_bad;
                        mem_read       <= ~sel_we & ~sel_bad;
                        busy           <= 1'b1;
                        state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Dropping mem_read here guarantees a fresh rising edge
                    // for every read.
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    state     <= RESP;
                end
                RESP: begin
                    if (!cur_we && !cur_bad) begin
                        if (grant_id) begin
                            m1_rdata <= mem_read_data;
                        end else begin
                            m0_rdata <= mem_read_data;
                        end
                    end
                    if (grant_id) begin
                        m1_ack <= 1'b1;
`ifdef ALIGN_CHECK_EN
                        m1_err <= cur_bad;
`endif
                    end else begin
                        m0_ack <= 1'b1;
`ifdef ALIGN_CHECK_EN
                        m0_err <= cur_bad;
`endif
                    end
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Bench for dmem_arbiter. The round-robin instance "dut" is attached to a
// behavioural byte memory (commits writes on the falling clock edge, loads
// read data on the rising edge of mem_read). A fixed-priority instance
// "dut_fp" is used for the starvation scenario. Expected results come from a
// transaction-level model: a byte array for memory contents, the tie-break
// rule, and "k-th served transaction acks 3*k cycles after the request".
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int MEM_SIZE = 1024;
    localparam bit RR       = 1'b1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- round-robin DUT signals ----------------
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack, m0_err;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack, m1_err;
    logic        mem_write, mem_read;
    logic [31:0] mem_address, mem_write_data;
    logic [31:0] mem_read_data = '0;
    logic        busy, grant_id;
    logic [1:0]  dbg_state;

    dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .ROUND_ROBIN(1'b1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy), .grant_id(grant_id), .dbg_state(dbg_state)
    );

    // ---------------- fixed-priority DUT signals ----------------
    logic        fp_m0_req = 1'b0, fp_m1_req = 1'b0;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err;
    logic        fp_mem_write, fp_mem_read;
    logic [31:0] fp_mem_address, fp_mem_write_data;
    logic [31:0] fp_mem_read_data = 32'h5A5A_5A5A;
    logic        fp_busy, fp_grant_id;
    logic [1:0]  fp_dbg_state;

    dmem_arbiter #(.MEM_SIZE(MEM_SIZE), .ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_req(fp_m0_req), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
        .m0_rdata(fp_m0_rdata), .m0_ack(fp_m0_ack), .m0_err(fp_m0_err),
        .m1_req(fp_m1_req), .m1_we(1'b0), .m1_addr(32'h8), .m1_wdata(32'h0),
        .m1_rdata(fp_m1_rdata), .m1_ack(fp_m1_ack), .m1_err(fp_m1_err),
        .mem_write(fp_mem_write), .mem_read(fp_mem_read),
        .mem_address(fp_mem_address), .mem_write_data(fp_mem_write_data),
        .mem_read_data(fp_mem_read_data),
        .busy(fp_busy), .grant_id(fp_grant_id), .dbg_state(fp_dbg_state)
    );

    // ---------------- behavioural memory ----------------
    bit [7:0] mem_bytes [MEM_SIZE];
    int rd_rises = 0;
    int wr_commits = 0;

    function automatic int bidx(input logic [31:0] a, input int k);
        return int'((a + 32'(k)) % 32'(MEM_SIZE));
    endfunction

    always @(negedge clk) begin
        if (mem_write) begin
            for (int k = 0; k < 4; k++) begin
                mem_bytes[bidx(mem_address, k)] <= mem_write_data[31 - 8 * k -: 8];
            end
            wr_commits <= wr_commits + 1;
        end
    end

    always @(posedge mem_read) begin
        rd_rises <= rd_rises + 1;
        #1;
        mem_read_data <= {mem_bytes[bidx(mem_address, 0)], mem_bytes[bidx(mem_address, 1)],
                          mem_bytes[bidx(mem_address, 2)], mem_bytes[bidx(mem_address, 3)]};
    end

    // ---------------- reference model ----------------
    bit [7:0]    ref_bytes [MEM_SIZE];
    logic [31:0] exp_rdata [2];
    int          last_g = 1;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_bytes[bidx(a, 0)], ref_bytes[bidx(a, 1)],
                ref_bytes[bidx(a, 2)], ref_bytes[bidx(a, 3)]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) ref_bytes[bidx(a, k)] = d[31 - 8 * k -: 8];
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
        return (a % 4 != 0) || (a > 32'(MEM_SIZE - 4));
`else
        return (a == 32'hFFFF_FFFF) && (a != 32'hFFFF_FFFF);
`endif
    endfunction

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive_master(input int m, input bit req, input bit we,
                                input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end
    endtask

    // Issue one request from m0 and/or m1 in the same cycle and check every
    // cycle until both are served.
    task automatic run_txn(input string tag,
                           input bit r0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                           input bit r1, input bit we1, input logic [31:0] a1, input logic [31:0] d1);
        bit          req_v [2];
        bit          we_v [2];
        logic [31:0] a_v [2];
        logic [31:0] d_v [2];
        int          t_ack [2];
        bit          bad [2];
        logic [31:0] new_rd [2];
        int          order [2];
        int          n, m, rd0, wr0, exp_rd, exp_wr;
        logic        ack_obs, err_obs;
        logic [31:0] rdata_obs;

        req_v[0] = r0; we_v[0] = we0; a_v[0] = a0; d_v[0] = d0;
        req_v[1] = r1; we_v[1] = we1; a_v[1] = a1; d_v[1] = d1;
        t_ack[0] = 0; t_ack[1] = 0;
        if (r0 && r1) begin
            order[0] = (RR && last_g == 0) ? 1 : 0;
            order[1] = 1 - order[0];
            n = 2;
        end else begin
            order[0] = r0 ? 0 : 1;
            order[1] = 0;
            n = 1;
        end
        exp_rd = 0; exp_wr = 0;
        for (int i = 0; i < n; i++) begin
            m = order[i];
            t_ack[m]  = 3 * (i + 1);
            bad[m]    = addr_bad(a_v[m]);
            new_rd[m] = exp_rdata[m];
            if (!bad[m]) begin
                if (we_v[m]) begin
                    ref_write(a_v[m], d_v[m]);
                    exp_wr++;
                end else begin
                    new_rd[m] = ref_word(a_v[m]);
                    exp_rd++;
                end
            end
            last_g = m;
        end

        rd0 = rd_rises; wr0 = wr_commits;
        drive_master(0, r0, we0, a0, d0);
        drive_master(1, r1, we1, a1, d1);
        for (int c = 1; c <= 3 * n; c++) begin
            @(negedge clk);
            check({tag, "_busy"}, busy, (c % 3) != 0);
            for (int mm = 0; mm < 2; mm++) begin
                ack_obs   = (mm == 0) ? m0_ack   : m1_ack;
                err_obs   = (mm == 0) ? m0_err   : m1_err;
                rdata_obs = (mm == 0) ? m0_rdata : m1_rdata;
                if (req_v[mm] && c == t_ack[mm]) begin
                    check({tag, "_ack"}, ack_obs, 1'b1);
                    check({tag, "_err"}, err_obs, bad[mm]);
                    check({tag, "_rdata"}, rdata_obs, new_rd[mm]);
                    check({tag, "_grant_id"}, grant_id, mm[0]);
                    check({tag, "_strobes_low"}, {mem_write, mem_read}, 2'b00);
                    exp_rdata[mm] = new_rd[mm];
                    drive_master(mm, 1'b0, 1'b0, 32'h0, 32'h0);
                end else begin
                    check({tag, "_no_ack"}, ack_obs, 1'b0);
                    check({tag, "_rdata_hold"}, rdata_obs, exp_rdata[mm]);
                    // Fields are latched at grant: disturbing them afterwards
                    // must not change the access.
                    if (req_v[mm] && (c == t_ack[mm] - 2 || c == t_ack[mm] - 1)) begin
                        drive_master(mm, 1'b1, $urandom_range(0, 1) == 1, $urandom, $urandom);
                    end
                end
            end
        end
        check({tag, "_read_strobes"}, rd_rises - rd0, exp_rd);
        check({tag, "_write_commits"}, wr_commits - wr0, exp_wr);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int acks0, acks1, sel;
        bit we0, we1;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {m0_ack, m1_ack}, 2'b00);
        check("rst_errs", {m0_err, m1_err}, 2'b00);
        check("rst_strobes", {mem_write, mem_read}, 2'b00);
        check("rst_m0_rdata", m0_rdata, 32'h0);
        check("rst_m1_rdata", m1_rdata, 32'h0);
        check("rst_grant_id", grant_id, 1'b0);
        check("rst_mem_address", mem_address, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Basic write then read-back by m0
        run_txn("t1_wr", 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        run_txn("t1_rd", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t1_rdata_const", m0_rdata, 32'hDEAD_BEEF);

        // Ties: first tie goes to m1 here because m0 was served last
        run_txn("t2_tie_a", 1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0);
        run_txn("t2_single", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_txn("t2_tie_b", 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);

        // Write/read race on the same word
        run_txn("t4_race_a", 1'b1, 1'b0, 32'h04, 32'h0, 1'b1, 1'b1, 32'h04, 32'h1122_3344);
        run_txn("t4_race_b", 1'b1, 1'b1, 32'h04, 32'h5566_7788, 1'b1, 1'b0, 32'h04, 32'h0);

        // Fixed priority starvation
        fp_m0_req = 1'b1; fp_m1_req = 1'b1;
        acks0 = 0; acks1 = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            acks0 += int'(fp_m0_ack);
            acks1 += int'(fp_m1_ack);
        end
        fp_m0_req = 1'b0; fp_m1_req = 1'b0;
        check("t3_m0_acks", acks0, 4);
        check("t3_m1_acks", acks1, 0);
        check("t3_m0_rdata", fp_m0_rdata, 32'h5A5A_5A5A);
        check("t3_m1_rdata", fp_m1_rdata, 32'h0);

        // Reset during the ACCESS cycle of an m0 write
        drive_master(0, 1'b1, 1'b1, 32'h20, 32'hCAFE_F00D);
        @(negedge clk);
        check("t5_write_strobe", mem_write, 1'b1);
        reset = 1'b1;
        drive_master(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("t5_busy", busy, 1'b0);
        check("t5_no_ack", m0_ack, 1'b0);
        reset = 1'b0;
        ref_write(32'h20, 32'hCAFE_F00D);
        last_g = 1;
        exp_rdata[0] = 32'h0;
        exp_rdata[1] = 32'h0;
        repeat (3) begin
            @(negedge clk);
            check("t5_quiet_ack", {m0_ack, m1_ack}, 2'b00);
        end
        run_txn("t5_rd", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("t5_rdata_const", m0_rdata, 32'hCAFE_F00D);

        // Alignment / range boundaries
        run_txn("t6_misaligned", 1'b1, 1'b0, 32'h02, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_txn("t6_top_minus2", 1'b1, 1'b0, 32'(MEM_SIZE - 2), 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        run_txn("t6_top_word_wr", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(MEM_SIZE - 4), 32'hA1B2_C3D4);
        run_txn("t6_top_word_rd", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'(MEM_SIZE - 4), 32'h0);
        run_txn("t6_past_end_wr", 1'b1, 1'b1, 32'(MEM_SIZE), 32'h0BAD_0BAD, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random traffic on a small window so reads hit earlier writes
        for (int i = 0; i < 25; i++) begin
            sel = $urandom_range(1, 3);
            we0 = $urandom_range(0, 1) == 1;
            we1 = $urandom_range(0, 1) == 1;
            run_txn("rnd",
                    sel[0], we0, 32'(4 * $urandom_range(0, 7)), $urandom,
                    sel[1], we1, 32'(4 * $urandom_range(0, 7)), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                check("rnd_gap_idle", {busy, m0_ack, m1_ack}, 3'b000);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
